// File: rtl/dac_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_cmd_sequencer
// Purpose  : Queues DAC write commands {chip, channel, 12-bit code} in a small
//            FIFO and feeds them one at a time to the I2C DAC write generator.
//            For each command it holds chip_id_out/dac_id_out/vol_out stable,
//            stretches start_out, and then waits for the writer's busy to rise
//            and fall. After that it inserts an idle gap before the next
//            command. If either wait runs too long, it sets a sticky timeout
//            flag and drops the command.
// Ports    : clk_in, reset_in (sync, active high)
//            cmd_valid_in/cmd_ready_out, cmd_chip_in, cmd_dac_in, cmd_vol_in
//            chip_id_out, dac_id_out, vol_out, start_out   (to writer)
//            writer_busy_in                                (from writer, async)
//            busy_out, fifo_count_out, done_pulse_out
//            timeout_err_out, err_clear_in
// Options  : DAC_VOL_CLAMP_EN - when defined, loaded codes are clamped to
//            VOL_MAX. When undefined, codes pass through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module dac_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int START_HOLD     = 128,
    parameter int GAP_CYCLES     = 256,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int VOL_MAX        = 4095
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          cmd_valid_in,
    output logic                          cmd_ready_out,
    input  logic                          cmd_chip_in,
    input  logic [3:0]                    cmd_dac_in,
    input  logic [11:0]                   cmd_vol_in,
    output logic                          chip_id_out,
    output logic [3:0]                    dac_id_out,
    output logic [11:0]                   vol_out,
    output logic                          start_out,
    input  logic                          writer_busy_in,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          done_pulse_out,
    output logic                          timeout_err_out,
    input  logic                          err_clear_in
);

    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_TMAX = (TIMEOUT_CYCLES > START_HOLD)
                          ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                          : ((START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES);
    localparam int c_CW   = $clog2(c_TMAX) + 1;

    localparam logic [c_AW:0]   c_DEPTH        = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_START_LAST   = c_CW'(START_HOLD - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST     = c_CW'(GAP_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TIMEOUT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]     c_VOL_MAX      = VOL_MAX[11:0];

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD      = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_ST_GAP       = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_busy_meta;
    logic            r_busy_sync;
    logic            w_set_err;
    logic            w_done;

    // Each FIFO entry is packed as {chip, dac[3:0], vol[11:0]}.
    logic [16:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic [16:0]     w_head;
    logic [11:0]     w_load_vol;

    logic            r_chip;
    logic [3:0]      r_dac;
    logic [11:0]     r_vol;
    logic            r_done;
    logic            r_err;

    // Ready comes from the registered count. A full FIFO therefore refuses a
    // push even in the cycle where LOAD pops an entry.
    assign cmd_ready_out = (r_count != c_DEPTH);
    assign w_push        = cmd_valid_in && cmd_ready_out;
    assign w_pop         = (r_state == c_ST_LOAD);
    assign w_head        = r_mem[r_rd_ptr];

`ifdef DAC_VOL_CLAMP_EN
    assign w_load_vol = (w_head[11:0] > c_VOL_MAX) ? c_VOL_MAX : w_head[11:0];
`else
    assign w_load_vol = w_head[11:0];
    wire w_unused_vol_max = ^c_VOL_MAX;
`endif

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_chip_in, cmd_dac_in, cmd_vol_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // writer_busy_in comes from another clock domain.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
        end else begin
            r_busy_meta <= writer_busy_in;
            r_busy_sync <= r_busy_meta;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_set_err    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (r_cnt == c_START_LAST) begin
                    w_next_state = c_ST_WAIT_BUSY;
                end
            end
            c_ST_WAIT_BUSY: begin
                if (r_busy_sync) begin
                    w_next_state = c_ST_WAIT_DONE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_set_err    = 1'b1;
                    w_next_state = c_ST_GAP;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!r_busy_sync) begin
                    w_done       = 1'b1;
                    w_next_state = c_ST_GAP;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_set_err    = 1'b1;
                    w_next_state = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // One shared cycle counter. It restarts on every state change, so each
    // timed state (START, both waits, GAP) measures from its own entry. It
    // saturates rather than wrapping.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_chip <= 1'b0;
            r_dac  <= 4'd0;
            r_vol  <= 12'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_chip <= w_head[16];
                r_dac  <= w_head[15:12];
                r_vol  <= w_load_vol;
            end
            r_done <= w_done;
            // A new timeout takes priority over a clear in the same cycle.
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (err_clear_in) begin
                r_err <= 1'b0;
            end
        end
    end

    assign chip_id_out     = r_chip;
    assign dac_id_out      = r_dac;
    assign vol_out         = r_vol;
    assign start_out       = (r_state == c_ST_START);
    assign busy_out        = (r_state != c_ST_IDLE);
    assign fifo_count_out  = r_count;
    assign done_pulse_out  = r_done;
    assign timeout_err_out = r_err;

endmodule
`default_nettype wire
